// File: rtl/pe_pkg.sv
// pe_pkg: shared types and helpers for the pe_simd slice.
// Holds the controller state enum, accumulator width and opsum saturation.
package pe_pkg;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_MAC,
    ST_FLUSH,
    ST_ACC,
    ST_OUT
  } pe_state_e;

  // Wide enough for any accumulator result up to 32-bit pixels.
  localparam int SAT_W = 68;

  function automatic int acc_w(input int dw);
    return 2 * dw + 4;
  endfunction

  localparam int ACC_WIDTH = acc_w(16);

  // Clamp v to the signed range of a dw-bit value.
  function automatic logic signed [SAT_W-1:0] saturate(
    input logic signed [SAT_W-1:0] v,
    input int                      dw
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) <<< (dw - 1)) - SAT_W'(1);
    lo = ~hi;
    if (v > hi)
      return hi;
    else if (v < lo)
      return lo;
    return v;
  endfunction

endpackage

// File: rtl/pe_mac_lane.sv
// pe_mac_lane: one filter lane; signed multiply, shift, product register
// and accumulator. Ports: clr_i/en_i control, a_i/w_i operands, acc_o sum.
module pe_mac_lane
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 0,
  localparam int AW        = acc_w(DATA_WIDTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr_i,
  input  logic                         en_i,
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] w_i,
  output logic signed [AW-1:0]         acc_o
);

  localparam int PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0] ax;
  logic signed [PW-1:0] wx;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] prod_q;
  logic                 pv_q;
  logic signed [AW-1:0] acc_q;

  assign ax   = PW'(a_i);
  assign wx   = PW'(w_i);
  assign prod = (ax * wx) >>> FRAC_BITS;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_q <= '0;
      pv_q   <= 1'b0;
      acc_q  <= '0;
    end else if (clr_i) begin
      pv_q   <= 1'b0;
      acc_q  <= '0;
    end else begin
      pv_q <= en_i;
      if (en_i)
        prod_q <= prod;
      if (pv_q)
        acc_q <= acc_q + AW'(prod_q);
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/pe_simd.sv
// pe_simd: row-stationary SIMD PE; LANES filters share one ifmap row.
// Ports: ifmap/filter/ipsum in, opsum out (valid/ready), busy, skip_count.
module pe_simd
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int LANES        = 2,
  parameter int IFMAP_DEPTH  = 12,
  parameter int FILTER_DEPTH = 112,
  parameter int FRAC_BITS    = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [4:0]                  S,
  input  logic [4:0]                  G,
  input  logic                        sat_en,
  input  logic                        keep_filter,
  input  logic [DATA_WIDTH-1:0]       ifmap_data,
  input  logic                        ifmap_valid,
  output logic                        ifmap_ready,
  input  logic [LANES*DATA_WIDTH-1:0] filter_data,
  input  logic                        filter_valid,
  output logic                        filter_ready,
  input  logic [DATA_WIDTH-1:0]       ipsum_data,
  input  logic                        ipsum_valid,
  output logic                        ipsum_ready,
  output logic [DATA_WIDTH-1:0]       opsum_data,
  output logic                        opsum_valid,
  input  logic                        opsum_ready,
  output logic                        busy,
  output logic [15:0]                 skip_count
);

  localparam int AW = acc_w(DATA_WIDTH);
  localparam int FW = LANES * DATA_WIDTH;
  localparam int IA = (IFMAP_DEPTH > 1) ? $clog2(IFMAP_DEPTH) : 1;
  localparam int FA = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [4:0]    IFM_MAX = 5'(IFMAP_DEPTH);
  localparam logic [9:0]    FLT_MAX = 10'(FILTER_DEPTH);
  localparam logic [LW-1:0] L_LAST  = LW'(LANES - 1);

  pe_state_e state_q, state_d;

  logic [4:0]             s_q, gn_q;
  logic                   sat_q, keep_q;
  logic [4:0]             g_q, g_d;
  logic [LW-1:0]          l_q, l_d;
  logic [4:0]             ifc_q;
  logic [9:0]             flc_q;
  logic [IFMAP_DEPTH-1:0] nz_q, used_q;
  logic [15:0]            skip_q, skip_d;
  logic signed [AW-1:0]   res_q;

  logic [DATA_WIDTH-1:0] ifm_q [IFMAP_DEPTH];
  logic [FW-1:0]         flt_q [FILTER_DEPTH];

  logic [9:0]             flt_need;
  logic                   ifm_full, flt_full, load_done;
  logic                   ifm_beat, flt_beat, ips_beat, ops_beat;
  logic [IFMAP_DEPTH-1:0] rem, pick, nxt_used;
  logic [IA-1:0]          sel;
  logic [FA-1:0]          fidx;
  logic [FW-1:0]          fword;
  logic                   mac_last, mac_en;
  logic                   mac_go, to_load;
  logic [4:0]             s_use;
  logic [16:0]            skip_sum;

  logic signed [AW-1:0]   acc [LANES];

  // Spad fill tracking; live S/G steer the fill, held copies drive the row.
  assign flt_need = 10'(S) * 10'(G);
  assign ifm_full = (ifc_q >= S) || (ifc_q >= IFM_MAX);
  assign flt_full = (flc_q >= flt_need) || (flc_q >= FLT_MAX);
  assign load_done = (state_q == ST_LOAD) && ifm_full && flt_full;

  assign ifmap_ready  = reset && (state_q == ST_LOAD) && !ifm_full;
  assign filter_ready = reset && (state_q == ST_LOAD) && !flt_full;
  assign ipsum_ready  = (state_q == ST_ACC);
  assign opsum_valid  = (state_q == ST_OUT);
  assign busy         = (state_q != ST_LOAD);

  assign ifm_beat = ifmap_valid && ifmap_ready;
  assign flt_beat = filter_valid && filter_ready;
  assign ips_beat = ipsum_valid && ipsum_ready;
  assign ops_beat = opsum_valid && opsum_ready;

  // Zero-skip: take the lowest nonzero tap not yet used in this group.
  assign rem      = nz_q & ~used_q;
  assign pick     = rem & (~rem + IFMAP_DEPTH'(1));
  assign nxt_used = used_q | pick;
  assign mac_last = (nz_q & ~nxt_used) == '0;
  assign mac_en   = (state_q == ST_MAC);

  always_comb begin
    sel = '0;
    for (int i = IFMAP_DEPTH - 1; i >= 0; i--)
      if (rem[i])
        sel = IA'(i);
  end

  assign fidx  = FA'(10'(g_q) * 10'(s_q) + 10'(sel));
  assign fword = flt_q[fidx];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    pe_mac_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .FRAC_BITS (FRAC_BITS)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .clr_i(mac_go),
      .en_i (mac_en),
      .a_i  (ifm_q[sel]),
      .w_i  (fword[l*DATA_WIDTH +: DATA_WIDTH]),
      .acc_o(acc[l])
    );
  end

  // Skipped taps are charged once per group as the group starts.
  assign s_use    = (state_q == ST_LOAD) ? S : s_q;
  assign skip_sum = {1'b0, skip_q} + 17'(s_use)
                  - 17'($countones(nz_q));
  assign skip_d   = skip_sum[16] ? 16'hFFFF : skip_sum[15:0];

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    l_d     = l_q;
    mac_go  = 1'b0;
    to_load = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        if (load_done) begin
          mac_go  = 1'b1;
          g_d     = '0;
          state_d = (nz_q == '0) ? ST_FLUSH : ST_MAC;
        end
      end
      ST_MAC: begin
        if (mac_last)
          state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        l_d     = '0;
        state_d = ST_ACC;
      end
      ST_ACC: begin
        if (ips_beat)
          state_d = ST_OUT;
      end
      ST_OUT: begin
        if (ops_beat) begin
          if (l_q != L_LAST) begin
            l_d     = l_q + LW'(1);
            state_d = ST_ACC;
          end else if (g_q != gn_q - 5'd1) begin
            g_d     = g_q + 5'd1;
            mac_go  = 1'b1;
            state_d = (nz_q == '0) ? ST_FLUSH : ST_MAC;
          end else begin
            to_load = 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_LOAD;
      g_q     <= '0;
      l_q     <= '0;
      s_q     <= '0;
      gn_q    <= '0;
      sat_q   <= 1'b0;
      keep_q  <= 1'b0;
      ifc_q   <= '0;
      flc_q   <= '0;
      nz_q    <= '0;
      used_q  <= '0;
      skip_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      l_q     <= l_d;
      if (load_done) begin
        s_q    <= S;
        gn_q   <= G;
        sat_q  <= sat_en;
        keep_q <= keep_filter;
      end
      if (ifm_beat) begin
        ifc_q                <= ifc_q + 5'd1;
        nz_q[ifc_q[IA-1:0]] <= |ifmap_data;
      end
      if (flt_beat)
        flc_q <= flc_q + 10'd1;
      if (mac_go) begin
        used_q <= '0;
        skip_q <= skip_d;
      end else if (mac_en) begin
        used_q <= nxt_used;
      end
      if (ips_beat)
        res_q <= acc[l_q] + AW'($signed(ipsum_data));
      if (to_load) begin
        ifc_q <= '0;
        nz_q  <= '0;
        if (!keep_q)
          flc_q <= '0;
      end
    end
  end

  // Spad contents need no reset; the fill counters gate every read.
  always_ff @(posedge clk) begin
    if (ifm_beat)
      ifm_q[ifc_q[IA-1:0]] <= ifmap_data;
    if (flt_beat)
      flt_q[flc_q[FA-1:0]] <= filter_data;
  end

  assign opsum_data = DATA_WIDTH'(sat_q
    ? saturate(SAT_W'(res_q), DATA_WIDTH)
    : SAT_W'(res_q));

  assign skip_count = skip_q;

endmodule

// File: tb/tb_pe_simd.sv
// tb_pe_simd: scoreboard bench for pe_simd.
// Rows go through the handshakes; opsums are popped and checked in order.
`timescale 1ns/1ps
module tb_pe_simd;

  localparam int DW = 16;
  localparam int LN = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [4:0]     S = 5'd1;
  logic [4:0]     G = 5'd1;
  logic           sat_en = 1'b0;
  logic           keep_filter = 1'b0;
  logic [DW-1:0]  ifmap_data = '0;
  logic           ifmap_valid = 1'b0;
  logic           ifmap_ready;
  logic [LN*DW-1:0] filter_data = '0;
  logic           filter_valid = 1'b0;
  logic           filter_ready;
  logic [DW-1:0]  ipsum_data = '0;
  logic           ipsum_valid = 1'b0;
  logic           ipsum_ready;
  logic [DW-1:0]  opsum_data;
  logic           opsum_valid;
  logic           opsum_ready = 1'b0;
  logic           busy;
  logic [15:0]    skip_count;

  pe_simd u_dut (
    .clk         (clk),
    .reset       (reset),
    .S           (S),
    .G           (G),
    .sat_en      (sat_en),
    .keep_filter (keep_filter),
    .ifmap_data  (ifmap_data),
    .ifmap_valid (ifmap_valid),
    .ifmap_ready (ifmap_ready),
    .filter_data (filter_data),
    .filter_valid(filter_valid),
    .filter_ready(filter_ready),
    .ipsum_data  (ipsum_data),
    .ipsum_valid (ipsum_valid),
    .ipsum_ready (ipsum_ready),
    .opsum_data  (opsum_data),
    .opsum_valid (opsum_valid),
    .opsum_ready (opsum_ready),
    .busy        (busy),
    .skip_count  (skip_count)
  );

  always #5 clk = ~clk;

  int     n_tot = 0;
  int     n_bad = 0;
  longint exp_q[$];
  longint skip_m = 0;

  int r_ifm [12];
  int r_flt [64][LN];
  int r_ips [64];

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic longint model(input int s, input int g,
                                   input int l, input int ips,
                                   input bit sat);
    longint acc;
    logic signed [15:0] lo;
    acc = ips;
    for (int t = 0; t < s; t++)
      acc += longint'(r_ifm[t]) * longint'(r_flt[g*s+t][l]);
    if (sat) begin
      if (acc > 32767) acc = 32767;
      else if (acc < -32768) acc = -32768;
      return acc;
    end
    lo = acc[15:0];
    return longint'(lo);
  endfunction

  task automatic push_ifm(input int v);
    int n = 0;
    ifmap_data  = DW'(v);
    ifmap_valid = 1'b1;
    while (!ifmap_ready && n < 50) begin
      @(negedge clk); n++;
    end
    if (!ifmap_ready) chk("ifm_to", ifmap_ready, 1);
    @(posedge clk); @(negedge clk);
    ifmap_valid = 1'b0;
  endtask

  task automatic push_flt(input int k);
    int n = 0;
    for (int l = 0; l < LN; l++)
      filter_data[l*DW +: DW] = DW'(r_flt[k][l]);
    filter_valid = 1'b1;
    while (!filter_ready && n < 50) begin
      @(negedge clk); n++;
    end
    if (!filter_ready) chk("flt_to", filter_ready, 1);
    @(posedge clk); @(negedge clk);
    filter_valid = 1'b0;
  endtask

  task automatic push_ips(input int v);
    int n = 0;
    ipsum_data  = DW'(v);
    ipsum_valid = 1'b1;
    while (!ipsum_ready && n < 200) begin
      @(negedge clk); n++;
    end
    if (!ipsum_ready) chk("ips_to", ipsum_ready, 1);
    @(posedge clk); @(negedge clk);
    ipsum_valid = 1'b0;
  endtask

  task automatic take_ops(input int stall);
    int n = 0;
    logic signed [15:0] sd;
    while (!opsum_valid && n < 50) begin
      @(negedge clk); n++;
    end
    if (!opsum_valid) chk("ops_to", opsum_valid, 1);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      sd = opsum_data;
      chk("stall_v", opsum_valid, 1);
      chk("stall_ir", ipsum_ready, 0);
      if (exp_q.size() > 0) chk("stall_d", sd, exp_q[0]);
    end
    sd = opsum_data;
    if (exp_q.size() == 0) chk("sb_empty", 0, 1);
    else chk("opsum", sd, exp_q.pop_front());
    opsum_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    opsum_ready = 1'b0;
  endtask

  task automatic run_row(input int s, input int g, input bit sat,
                         input bit keep, input bit send_flt,
                         input int stall);
    int n, cyc, p;
    S = 5'(s); G = 5'(g);
    sat_en = sat; keep_filter = keep;
    for (int k = 0; k < g*LN; k++)
      exp_q.push_back(model(s, k/LN, k%LN, r_ips[k], sat));
    p = 0;
    for (int t = 0; t < s; t++)
      if (r_ifm[t] != 0) p++;
    skip_m += longint'(g * (s - p));
    if (skip_m > 65535) skip_m = 65535;
    if (!send_flt) chk("flt_rdy_keep0", filter_ready, 0);
    for (int t = 0; t < s; t++) push_ifm(r_ifm[t]);
    if (send_flt)
      for (int k = 0; k < s*g; k++) push_flt(k);
    else
      chk("flt_rdy_keep1", filter_ready, 0);
    n = 0;
    while (!busy && n < 50) begin
      @(negedge clk); n++;
    end
    if (!busy) chk("busy_to", busy, 1);
    cyc = 0;
    while (!ipsum_ready && cyc < 200) begin
      @(negedge clk); cyc++;
    end
    chk("mac_cyc", cyc - 1, p);
    for (int k = 0; k < g*LN; k++) begin
      push_ips(r_ips[k]);
      take_ops(k == 0 ? stall : 0);
    end
    chk("skip", skip_count, skip_m);
    chk("busy_end", busy, 0);
  endtask

  task automatic set_base();
    r_ifm[0] = 1; r_ifm[1] = 2; r_ifm[2] = 3;
    r_flt[0][0] = 1; r_flt[0][1] = 2;
    r_flt[1][0] = 1; r_flt[1][1] = 0;
    r_flt[2][0] = 1; r_flt[2][1] = -1;
    r_ips[0] = 10; r_ips[1] = 20;
  endtask

  function automatic int rnd_px();
    if ($urandom_range(0, 3) == 0) return 0;
    return int'($urandom_range(0, 600)) - 300;
  endfunction

  initial begin
    int s, g;
    bit sat;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ov", opsum_valid, 0);
    chk("rst_od", opsum_data, 0);
    chk("rst_ir", ipsum_ready, 0);
    chk("rst_ifr", ifmap_ready, 0);
    chk("rst_ffr", filter_ready, 0);
    chk("rst_skip", skip_count, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_ifr", ifmap_ready, 1);

    set_base();
    run_row(3, 1, 0, 0, 1, 0);

    r_ifm[0] = 0; r_ifm[1] = 5; r_ifm[2] = 0;
    run_row(3, 1, 0, 1, 1, 0);

    r_ifm[0] = 1; r_ifm[1] = 2; r_ifm[2] = 3;
    r_ips[0] = 0; r_ips[1] = 0;
    run_row(3, 1, 0, 0, 0, 5);

    r_ifm[0] = 32767;
    r_flt[0][0] = 32767; r_flt[0][1] = -32768;
    run_row(1, 1, 1, 0, 1, 0);
    run_row(1, 1, 0, 0, 1, 0);

    r_ifm[0] = 3; r_ifm[1] = 0; r_ifm[2] = -7; r_ifm[3] = 100;
    for (int k = 0; k < 8; k++)
      for (int l = 0; l < LN; l++)
        r_flt[k][l] = int'($urandom_range(0, 600)) - 300;
    for (int k = 0; k < 4; k++)
      r_ips[k] = int'($urandom_range(0, 2000)) - 1000;
    run_row(4, 2, 1, 0, 1, 0);

    for (int it = 0; it < 3; it++) begin
      s = int'($urandom_range(1, 12));
      g = int'($urandom_range(1, 3));
      sat = 1'($urandom_range(0, 1));
      for (int t = 0; t < s; t++) r_ifm[t] = rnd_px();
      for (int k = 0; k < s*g; k++)
        for (int l = 0; l < LN; l++) r_flt[k][l] = rnd_px();
      for (int k = 0; k < g*LN; k++)
        r_ips[k] = int'($urandom_range(0, 60000)) - 30000;
      run_row(s, g, sat, 0, 1, 0);
    end

    set_base();
    S = 5'd3; G = 5'd1; sat_en = 1'b0; keep_filter = 1'b0;
    for (int t = 0; t < 3; t++) push_ifm(r_ifm[t]);
    for (int k = 0; k < 3; k++) push_flt(k);
    push_ips(r_ips[0]);
    chk("pre_rst_ov", opsum_valid, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_ov", opsum_valid, 0);
    chk("mid_rst_skip", skip_count, 0);
    chk("mid_rst_busy", busy, 0);
    exp_q.delete();
    skip_m = 0;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_stale_ops", opsum_valid, 0);
    end
    r_ifm[0] = 0; r_ifm[1] = 4; r_ifm[2] = -2;
    run_row(3, 1, 0, 0, 1, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/pe_simd.md
PE_SIMD -- requirements
Module: pe_simd

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning the signed pixel width for ifmap, filter, ipsum and opsum.
REQ-002 SHALL have parameter LANES, default 2, meaning the number of filters processed in parallel.
REQ-003 SHALL have parameter IFMAP_DEPTH, default 12, meaning the maximum taps S.
REQ-004 SHALL have parameter FILTER_DEPTH, default 112, meaning the filter spad depth in LANES-wide words.
REQ-005 SHALL have parameter FRAC_BITS, default 0, meaning the arithmetic right shift applied to each product.
REQ-006 SHALL have ports clk (in, 1, clock) and reset (in, 1, asynchronous, active-low).
REQ-007 SHALL have ports S (in, 5, taps per row, 1..IFMAP_DEPTH) and G (in, 5, filter groups, each of LANES filters, 1..).
REQ-008 SHALL have ports sat_en (in, 1, saturate opsum) and keep_filter (in, 1, retain filter spad after a row).
REQ-009 SHALL have ports ifmap_data (in, DATA_WIDTH), ifmap_valid (in, 1) and ifmap_ready (out, 1).
REQ-010 SHALL have ports filter_data (in, LANES*DATA_WIDTH; lane l in bits [l*DATA_WIDTH +: DATA_WIDTH]), filter_valid (in, 1) and filter_ready (out, 1).
REQ-011 SHALL have ports ipsum_data (in, DATA_WIDTH), ipsum_valid (in, 1) and ipsum_ready (out, 1).
REQ-012 SHALL have ports opsum_data (out, DATA_WIDTH), opsum_valid (out, 1) and opsum_ready (in, 1).
REQ-013 SHALL have ports busy (out, 1, state is not LOAD) and skip_count (out, 16, saturating count of skipped zero taps).

Function
REQ-014 Transfers: a beat SHALL occur when valid and ready are both high at a rising edge of clk; data SHALL be held while valid is high and ready is low.
REQ-015 States: LOAD, MAC, FLUSH, ACC, OUT.
REQ-016 LOAD: ifmap_ready SHALL be high while fewer than S ifmap beats have been taken; filter_ready SHALL be high while fewer than S*G filter words are held. Filter word k holds tap k mod S for filters (k/S)*LANES+l.
REQ-017 LOAD SHALL go to MAC with group g=0 once both spads are full.
REQ-018 Each ifmap write SHALL set nz[s] = (pixel != 0).
REQ-019 MAC: each cycle SHALL select the lowest tap with nz[s]=1 not yet used in the current group; zero taps SHALL consume no cycle. MAC SHALL take exactly popcount(nz) cycles per group. With nz=0, MAC SHALL go straight to FLUSH.
REQ-020 Product: full 2*DATA_WIDTH signed, arithmetic right shift by FRAC_BITS, registered one stage, then added into a per-lane accumulator of 2*DATA_WIDTH+4 bits. Accumulators SHALL clear on MAC entry.
REQ-021 FLUSH: one cycle draining the product register, then ACC with lane l=0.
REQ-022 ACC: ipsum_ready SHALL be high. On an ipsum beat, the sign-extended ipsum SHALL be added to accumulator l, the result registered, and the state SHALL go to OUT.
REQ-023 OUT: opsum_valid SHALL be high. opsum_data SHALL be the result clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] if sat_en=1, else its low DATA_WIDTH bits.
REQ-024 OUT on an opsum beat: if l<LANES-1, l++ and go to ACC; else if g<G-1, g++ and go to MAC; else go to LOAD.
REQ-025 Opsum order SHALL be filter index ascending, g*LANES+l.
REQ-026 Return to LOAD SHALL always clear the ifmap spad and nz. The filter spad SHALL be cleared only if keep_filter=0; if keep_filter=1, LOAD SHALL wait for the ifmap spad only.
REQ-027 skip_count SHALL add S-popcount(nz) once per group at MAC entry and SHALL saturate at 16'hFFFF.
REQ-028 S, G, sat_en and keep_filter SHALL be sampled at LOAD exit and held until the next LOAD; changes mid-row SHALL be ignored.
REQ-029 Ifmap and filter beats SHALL be accepted only in LOAD.

Reset
REQ-030 reset low SHALL asynchronously force state LOAD, g=l=0, both spads empty, nz=0, accumulators 0, skip_count 0, opsum_data 0, opsum_valid 0, ipsum_ready 0 and busy 0. ifmap_ready and filter_ready SHALL be 0 while reset is asserted.
REQ-031 Reset mid-row SHALL discard all partial results; no opsum beat SHALL follow until a complete new row is loaded.

Structure
REQ-032 The shared package pe_pkg SHALL hold the state enum, ACC_WIDTH and the saturate function.
REQ-033 A single sub-module pe_mac_lane (multiply, shift, product register, accumulator) SHALL be instantiated LANES times. The controller and spads SHALL be inline.

Verification
REQ-034 S=3, G=1, LANES=2, ifmap {1,2,3}, filters {1,1,1} and {2,0,-1}, ipsum {10,20} -> opsum 16 then 19; MAC lasts 3 cycles.
REQ-035 Ifmap {0,5,0}, same filters -> MAC lasts 1 cycle; skip_count=2; opsum {15,20}.
REQ-036 sat_en=1, ifmap 0x7FFF, filter 0x7FFF, ipsum 0 -> opsum 0x7FFF. The same stimulus with sat_en=0 -> opsum 0x0001.
REQ-037 opsum_ready held low for 5 cycles -> opsum_data stable and opsum_valid high throughout; ipsum_ready low.
REQ-038 keep_filter=1 -> second row needs only 3 ifmap beats, and filter_ready stays low.
REQ-039 reset asserted during OUT -> opsum_valid falls immediately and skip_count=0; the next row produces correct results.
